signal_lamp_monitor: RTL
========================

Name: signal_lamp_monitor

Overview:
Safety stage directly downstream of the four-way traffic controller. It consumes the per-approach 3-bit light codes (n/s/e/w) and drives the physical red/yellow/green lamp enables. It detects conflicting or invalid light combinations and over-long greens, and forces a latched flashing-red fault mode that only an explicit clear followed by a clean input window can exit.

Parameters:
CONFIRM_CYC, 2, consecutive conflicting cycles required to declare a conflict fault (1..255)
MAX_GREEN, 16, consecutive cycles one approach may stay green before a watchdog fault (1..255)
FLASH_CYC, 4, cycles per half-period of the fault red flash (1..255)
RECOVER_CYC, 4, consecutive conflict-free cycles required in RECOVER before returning to NORMAL (1..255)

Ports:
clk  input  1  system clock, all state on rising edge
rst_a  input  1  asynchronous, active-low reset
n_light  input  3  north code: 000 red, 001 green, 010 yellow, others invalid
s_light  input  3  south code, same encoding
e_light  input  3  east code, same encoding
w_light  input  3  west code, same encoding
clear_fault  input  1  operator clear, sampled level, acted on only in FAULT
lamp_r  output  4  red lamp enables {w,e,s,n}
lamp_y  output  4  yellow lamp enables {w,e,s,n}
lamp_g  output  4  green lamp enables {w,e,s,n}
fault  output  1  high in FAULT and RECOVER
fault_code  output  2  00 none, 01 conflict/invalid, 10 green watchdog
mon_state  output  2  00 NORMAL, 01 CONFIRM, 10 FAULT, 11 RECOVER

Behaviour:
- Reset (rst_a low, asynchronous): state NORMAL; lamp_r=4'hF, lamp_y=0, lamp_g=0; fault=0; fault_code=00; all counters 0; flash phase=1. Reset mid-operation aborts any state immediately.
- All outputs registered; lamps reflect inputs sampled on the previous edge (1-cycle latency).
- conflict_now = any input code invalid, OR more than one approach non-red (green or yellow).
- green_cnt: counts consecutive sampled cycles in which the same single approach is green. Resets to 0 when no approach is green, the green approach changes, or state is not NORMAL. Counter width 8 bits, saturating.
- NORMAL: if no conflict, each approach lamp is a one-hot decode of its code (red→r, yellow→y, green→g). On conflict_now: conf_cnt=1; if CONFIRM_CYC=1 go FAULT (code 01) else go CONFIRM; lamps all steady red. If green_cnt would reach MAX_GREEN on this edge: go FAULT, code 10. Conflict takes priority over watchdog on the same cycle.
- CONFIRM: lamps steady all red. conflict_now → conf_cnt+1; when it reaches CONFIRM_CYC go FAULT, code 01. No conflict → back to NORMAL with decoded lamps on that edge; conf_cnt cleared.
- FAULT: fault=1, fault_code held. lamp_y=lamp_g=0; lamp_r={4{phase}}; phase starts at 1 on entry and toggles every FLASH_CYC cycles. Inputs ignored. clear_fault high → RECOVER, clean_cnt=0.
- RECOVER: fault=1, fault_code held; lamps steady all red. Each cycle with no conflict increments clean_cnt; any conflict resets it to 0. When clean_cnt reaches RECOVER_CYC: go NORMAL, fault=0, fault_code=00, lamps decoded from the inputs on that edge.
- clear_fault is ignored in NORMAL, CONFIRM and RECOVER.
- At no time do lamp outputs show two non-red approaches or more than one lamp lit per approach.

Test Plan:
1. Hold rst_a low mid-green, then release → lamp_r=F, lamp_y=0, lamp_g=0, fault=0, mon_state=00 immediately. After release with n=001 and others 000, one cycle later lamp_g=0001 and lamp_r=1110.
2. Drive the upstream sequence (n green 8 cycles, n yellow 4 cycles, s green, ...) → lamps track with 1-cycle lag, fault stays 0, no all-red inserted at handoffs.
3. n=001 and s=001 for exactly 1 cycle → lamps all red for 1 cycle, mon_state 01 for 1 cycle, fault=0, then normal decode resumes.
4. e=011 (invalid) held for 2 cycles → fault=1 and fault_code=01 after the 2nd edge. lamp_r alternates F (4 cycles) / 0 (4 cycles), lamp_g=lamp_y=0.
5. n=001 held for 16 cycles → fault=1 and fault_code=10 on the edge after the 16th sample. The same test with 15 cycles followed by n=010 → no fault.
6. In FAULT, pulse clear_fault, then apply clean codes with one invalid code on the 2nd cycle → clean_cnt restarts. 4 further clean cycles → mon_state=00, fault=0, fault_code=00.

Source files
------------

// File: rtl/signal_lamp_monitor.sv
// Safety stage between the four-way controller and the lamp drivers: decodes
// light codes to lamp enables and latches a flashing-red fault on conflicts or over-long greens.
module signal_lamp_monitor #(
  parameter int unsigned CONFIRM_CYC = 2,
  parameter int unsigned MAX_GREEN   = 16,
  parameter int unsigned FLASH_CYC   = 4,
  parameter int unsigned RECOVER_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [2:0] n_light,
  input  logic [2:0] s_light,
  input  logic [2:0] e_light,
  input  logic [2:0] w_light,
  input  logic       clear_fault,
  output logic [3:0] lamp_r,
  output logic [3:0] lamp_y,
  output logic [3:0] lamp_g,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [1:0] mon_state
);

  typedef enum logic [1:0] {
    NORMAL  = 2'b00,
    CONFIRM = 2'b01,
    FAULT   = 2'b10,
    RECOVER = 2'b11
  } state_t;

  localparam logic [7:0] CONF_LIM  = 8'(CONFIRM_CYC);
  localparam logic [7:0] GREEN_LIM = 8'(MAX_GREEN);
  localparam logic [7:0] FLASH_LIM = 8'(FLASH_CYC);
  localparam logic [7:0] REC_LIM   = 8'(RECOVER_CYC);

  state_t     state_q, state_d;
  logic [7:0] conf_q, conf_d;
  logic [7:0] clean_q, clean_d;
  logic [7:0] flash_q, flash_d;
  logic [7:0] green_q, green_d;
  logic [1:0] gidx_q, gidx_d;
  logic       phase_q, phase_d;
  logic [3:0] r_d, y_d, g_d;
  logic       fault_d;
  logic [1:0] code_d;

  logic [3:0] is_red, is_yel, is_grn, is_bad;
  logic       conflict_now;
  logic [1:0] gidx_now;
  logic [7:0] green_cand;

  assign is_red = {w_light == 3'b000, e_light == 3'b000, s_light == 3'b000, n_light == 3'b000};
  assign is_grn = {w_light == 3'b001, e_light == 3'b001, s_light == 3'b001, n_light == 3'b001};
  assign is_yel = {w_light == 3'b010, e_light == 3'b010, s_light == 3'b010, n_light == 3'b010};
  assign is_bad = {w_light > 3'b010, e_light > 3'b010, s_light > 3'b010, n_light > 3'b010};

  assign conflict_now = (|is_bad) || ($countones(~is_red) > 1);
  assign gidx_now = is_grn[3] ? 2'd3 : is_grn[2] ? 2'd2 : is_grn[1] ? 2'd1 : 2'd0;

  // Run length of the current single green including this sample; a zero
  // count means no run in progress, so any green starts afresh at 1.
  always_comb begin
    green_cand = '0;
    if (!conflict_now && (|is_grn)) begin
      if (gidx_now == gidx_q && green_q != '0)
        green_cand = (green_q == 8'hFF) ? 8'hFF : green_q + 8'd1;
      else
        green_cand = 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    conf_d  = conf_q;
    clean_d = clean_q;
    flash_d = flash_q;
    phase_d = phase_q;
    green_d = '0;
    gidx_d  = gidx_q;
    r_d     = '1;
    y_d     = '0;
    g_d     = '0;
    fault_d = fault;
    code_d  = fault_code;

    case (state_q)
      NORMAL: begin
        if (conflict_now) begin
          conf_d = 8'd1;
          if (CONF_LIM == 8'd1) begin
            state_d = FAULT;
            code_d  = 2'b01;
          end else begin
            state_d = CONFIRM;
          end
        end else if (green_cand >= GREEN_LIM) begin
          state_d = FAULT;
          code_d  = 2'b10;
        end else begin
          r_d     = is_red;
          y_d     = is_yel;
          g_d     = is_grn;
          green_d = green_cand;
          gidx_d  = gidx_now;
        end
      end
      CONFIRM: begin
        if (conflict_now) begin
          conf_d = conf_q + 8'd1;
          if (conf_d >= CONF_LIM) begin
            state_d = FAULT;
            code_d  = 2'b01;
          end
        end else begin
          state_d = NORMAL;
          conf_d  = '0;
          r_d     = is_red;
          y_d     = is_yel;
          g_d     = is_grn;
          green_d = green_cand;
          gidx_d  = gidx_now;
        end
      end
      FAULT: begin
        if (clear_fault) begin
          state_d = RECOVER;
          clean_d = '0;
        end else begin
          if (flash_q >= FLASH_LIM - 8'd1) begin
            flash_d = '0;
            phase_d = ~phase_q;
          end else begin
            flash_d = flash_q + 8'd1;
          end
          r_d = {4{phase_d}};
        end
      end
      RECOVER: begin
        if (conflict_now) begin
          clean_d = '0;
        end else if (clean_q + 8'd1 >= REC_LIM) begin
          state_d = NORMAL;
          clean_d = '0;
          fault_d = 1'b0;
          code_d  = 2'b00;
          r_d     = is_red;
          y_d     = is_yel;
          g_d     = is_grn;
          green_d = green_cand;
          gidx_d  = gidx_now;
        end else begin
          clean_d = clean_q + 8'd1;
        end
      end
      default: state_d = NORMAL;
    endcase

    // Every path into FAULT restarts the flash on the lit half-period.
    if (state_d == FAULT && state_q != FAULT) begin
      fault_d = 1'b1;
      phase_d = 1'b1;
      flash_d = '0;
      conf_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q    <= NORMAL;
      conf_q     <= '0;
      clean_q    <= '0;
      flash_q    <= '0;
      green_q    <= '0;
      gidx_q     <= '0;
      phase_q    <= 1'b1;
      lamp_r     <= '1;
      lamp_y     <= '0;
      lamp_g     <= '0;
      fault      <= 1'b0;
      fault_code <= '0;
    end else begin
      state_q    <= state_d;
      conf_q     <= conf_d;
      clean_q    <= clean_d;
      flash_q    <= flash_d;
      green_q    <= green_d;
      gidx_q     <= gidx_d;
      phase_q    <= phase_d;
      lamp_r     <= r_d;
      lamp_y     <= y_d;
      lamp_g     <= g_d;
      fault      <= fault_d;
      fault_code <= code_d;
    end
  end

  assign mon_state = state_q;

endmodule
